// File: rtl/hqm_system_mem_rf_pg_ctl.sv
// rtl/hqm_system_mem_rf_pg_ctl.sv - power-gated two-port register file with wake/init/sleep sequencing
module hqm_system_mem_rf_pg_ctl #(
    parameter int DEPTH    = 64,
    parameter int DWIDTH   = 6,
    parameter int AWIDTH   = $clog2(DEPTH),
    parameter int WAKE_CYC = 4,
    parameter int INIT_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata,
    output logic              rvalid,
    input  logic              pwr_req,
    output logic              pwr_ack,
    output logic              isol_en,
    output logic              pwr_enable_b_out,
    output logic              busy,
    output logic              access_err,
    input  logic              err_clr
);

    localparam int WCW = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
    localparam logic [WCW-1:0]    WAKE_LOAD = WCW'(WAKE_CYC - 1);
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);
    localparam logic [AWIDTH:0]   DEPTH_X   = (AWIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_WAKE  = 3'd1,
        S_INIT  = 3'd2,
        S_ON    = 3'd3,
        S_SLEEP = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WCW-1:0]    wake_cnt;
    logic [AWIDTH-1:0] init_addr;
    logic [DWIDTH-1:0] mem [DEPTH];

    logic is_on;
    logic wr_ok;
    logic rd_ok;
    logic rd_in_range;
    logic violation;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_OFF: begin
                if (pwr_req) state_nxt = S_WAKE;
            end
            S_WAKE: begin
                if (!pwr_req) state_nxt = S_SLEEP;
                else if (wake_cnt == '0) state_nxt = (INIT_EN != 0) ? S_INIT : S_ON;
            end
            S_INIT: begin
                if (!pwr_req) state_nxt = S_SLEEP;
                else if (init_addr == LAST_ADDR) state_nxt = S_ON;
            end
            S_ON: begin
                if (!pwr_req) state_nxt = S_SLEEP;
            end
            S_SLEEP: state_nxt = S_OFF;
            default: state_nxt = S_OFF;
        endcase
    end

    // Isolation is asserted in every state where the array supply may be ramping or off
    always_comb begin
        pwr_enable_b_out = 1'b1;
        isol_en          = 1'b1;
        pwr_ack          = 1'b0;
        busy             = 1'b0;
        case (state)
            S_OFF: begin
                pwr_enable_b_out = 1'b1;
                isol_en          = 1'b1;
            end
            S_WAKE: begin
                pwr_enable_b_out = 1'b0;
                isol_en          = 1'b1;
                busy             = 1'b1;
            end
            S_INIT: begin
                pwr_enable_b_out = 1'b0;
                isol_en          = 1'b0;
                busy             = 1'b1;
            end
            S_ON: begin
                pwr_enable_b_out = 1'b0;
                isol_en          = 1'b0;
                pwr_ack          = 1'b1;
            end
            S_SLEEP: begin
                pwr_enable_b_out = 1'b0;
                isol_en          = 1'b1;
                busy             = 1'b1;
            end
            default: begin
                pwr_enable_b_out = 1'b1;
                isol_en          = 1'b1;
            end
        endcase
    end

    // Counters park at their start values outside their state, so entry needs no extra load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wake_cnt  <= WAKE_LOAD;
            init_addr <= '0;
        end else begin
            if (state != S_WAKE) wake_cnt <= WAKE_LOAD;
            else if (wake_cnt != '0) wake_cnt <= wake_cnt - 1'b1;

            if (state == S_INIT) init_addr <= init_addr + 1'b1;
            else init_addr <= '0;
        end
    end

    assign is_on       = (state == S_ON);
    assign rd_in_range = ({1'b0, raddr} < DEPTH_X);
    assign wr_ok       = is_on && we && ({1'b0, waddr} < DEPTH_X);
    assign rd_ok       = is_on && re;
    assign violation   = !is_on && (we || re);

    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            mem[init_addr] <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid     <= 1'b0;
            rdata      <= '0;
            access_err <= 1'b0;
        end else begin
            rvalid <= rd_ok;
            if (rd_ok) rdata <= rd_in_range ? mem[raddr] : '0;
            if (violation) access_err <= 1'b1;
            else if (err_clr) access_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hqm_system_mem_rf_pg_ctl.sv
// tb/tb_hqm_system_mem_rf_pg_ctl.sv - directed bench for the power-gated register file
module tb_hqm_system_mem_rf_pg_ctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, we, re, pwr_req, err_clr;
    logic [5:0] waddr, wdata, raddr, rdata;
    logic       rvalid, pwr_ack, isol_en, pwr_enable_b_out, busy, access_err;

    logic        rst2_n, we2, re2, pwr_req2, err_clr2;
    logic [5:0]  waddr2, raddr2;
    logic [32:0] wdata2, rdata2;
    logic        rvalid2, pwr_ack2, isol_en2, pwr_enable_b_out2, busy2, access_err2;

    hqm_system_mem_rf_pg_ctl dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
        .pwr_req(pwr_req), .pwr_ack(pwr_ack), .isol_en(isol_en),
        .pwr_enable_b_out(pwr_enable_b_out), .busy(busy),
        .access_err(access_err), .err_clr(err_clr)
    );

    hqm_system_mem_rf_pg_ctl #(.DEPTH(48), .DWIDTH(33), .WAKE_CYC(1), .INIT_EN(0)) dut2 (
        .clk(clk), .rst_n(rst2_n), .we(we2), .waddr(waddr2), .wdata(wdata2),
        .re(re2), .raddr(raddr2), .rdata(rdata2), .rvalid(rvalid2),
        .pwr_req(pwr_req2), .pwr_ack(pwr_ack2), .isol_en(isol_en2),
        .pwr_enable_b_out(pwr_enable_b_out2), .busy(busy2),
        .access_err(access_err2), .err_clr(err_clr2)
    );

    typedef struct {
        logic       we;
        logic [5:0] waddr;
        logic [5:0] wdata;
        logic       re;
        logic [5:0] raddr;
        logic       pwr_req;
        logic       err_clr;
        logic       e_rvalid;
        logic [5:0] e_rdata;
        logic       e_ack;
        logic       e_isol;
        logic       e_penb;
        logic       e_busy;
        logic       e_err;
    } vec_t;

    vec_t vecs [14];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_safe();
        chk1("isol_vs_power", !(isol_en == 1'b0 && pwr_enable_b_out == 1'b1), 1'b1);
    endtask

    // Drives pwr_req high from OFF and follows the edge-by-edge wake/init timeline
    task automatic power_up(input bit probe);
        pwr_req = 1'b1;
        for (int t = 1; t <= 69; t++) begin
            we = 1'b0; re = 1'b0; err_clr = 1'b0;
            if (probe && t == 2) begin we = 1'b1; waddr = 6'd3; wdata = 6'h3F; end
            if (probe && t == 10) begin re = 1'b1; raddr = 6'd0; err_clr = 1'b1; end
            if (probe && t == 11) err_clr = 1'b1;
            tick();
            chk_safe();
            if (t == 1) begin
                chk1("wake_penb", pwr_enable_b_out, 1'b0);
                chk1("wake_isol", isol_en, 1'b1);
                chk1("wake_busy", busy, 1'b1);
            end
            if (t == 4) chk1("wake_last_isol", isol_en, 1'b1);
            if (t == 5) chk1("init_isol", isol_en, 1'b0);
            if (probe && t == 2) chk1("err_in_wake", access_err, 1'b1);
            if (probe && t == 10) begin
                chk1("err_set_wins", access_err, 1'b1);
                chk1("init_no_rvalid", rvalid, 1'b0);
            end
            if (probe && t == 11) chk1("err_clr", access_err, 1'b0);
            if (t == 68) begin
                chk1("ack_before_69", pwr_ack, 1'b0);
                chk1("init_busy", busy, 1'b1);
            end
            if (t == 69) begin
                chk1("ack_at_69", pwr_ack, 1'b1);
                chk1("on_busy", busy, 1'b0);
                chk1("on_isol", isol_en, 1'b0);
            end
        end
        we = 1'b0; re = 1'b0; err_clr = 1'b0;
    endtask

    task automatic read_all_zero();
        for (int i = 0; i < 64; i++) begin
            re = 1'b1; raddr = 6'(i);
            tick();
            chk1($sformatf("rd_all_rvalid[%0d]", i), rvalid, 1'b1);
            chkv($sformatf("rd_all_rdata[%0d]", i), 64'(rdata), 64'd0);
        end
        re = 1'b0;
        tick();
        chk1("rd_all_idle_rvalid", rvalid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //               we    waddr   wdata  re    raddr  req   clr   rv    rdata  ack   isol  penb  busy  err
        vecs[0]  = '{1'b1, 6'd5,  6'h2A, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 6'd0,  6'h00, 1'b1, 6'd5,  1'b1, 1'b0, 1'b1, 6'h2A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 6'd5,  6'h15, 1'b1, 6'd5,  1'b1, 1'b0, 1'b1, 6'h2A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 6'd0,  6'h00, 1'b1, 6'd5,  1'b1, 1'b0, 1'b1, 6'h15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 6'd6,  6'h3C, 1'b1, 6'd6,  1'b1, 1'b0, 1'b1, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 6'd63, 6'h01, 1'b1, 6'd6,  1'b1, 1'b0, 1'b1, 6'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 6'd0,  6'h00, 1'b1, 6'd63, 1'b1, 1'b0, 1'b1, 6'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 6'd0,  6'h00, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 6'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 6'd0,  6'h3F, 1'b1, 6'd5,  1'b1, 1'b0, 1'b1, 6'h15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 6'd0,  6'h00, 1'b1, 6'd0,  1'b1, 1'b0, 1'b1, 6'h3F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 6'd0,  6'h00, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 6'h3F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 6'd0,  6'h00, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 6'h3F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 6'd0,  6'h00, 1'b1, 6'd5,  1'b0, 1'b0, 1'b0, 6'h3F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 6'd0,  6'h00, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 6'h3F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; we = 1'b0; re = 1'b0; pwr_req = 1'b0; err_clr = 1'b0;
        waddr = '0; wdata = '0; raddr = '0;
        rst2_n = 1'b0; we2 = 1'b0; re2 = 1'b0; pwr_req2 = 1'b0; err_clr2 = 1'b0;
        waddr2 = '0; wdata2 = '0; raddr2 = '0;
        tick();
        tick();
        chk1("rst_penb", pwr_enable_b_out, 1'b1);
        chk1("rst_isol", isol_en, 1'b1);
        chk1("rst_ack", pwr_ack, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rvalid", rvalid, 1'b0);
        chk1("rst_err", access_err, 1'b0);
        chkv("rst_rdata", 64'(rdata), 64'd0);
        rst_n = 1'b1; rst2_n = 1'b1;
        tick();
        chk1("off_idle_penb", pwr_enable_b_out, 1'b1);

        power_up(1'b1);
        read_all_zero();

        for (int i = 0; i < 14; i++) begin
            we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            re = vecs[i].re; raddr = vecs[i].raddr;
            pwr_req = vecs[i].pwr_req; err_clr = vecs[i].err_clr;
            tick();
            chk_safe();
            chk1($sformatf("vec%0d_rvalid", i), rvalid, vecs[i].e_rvalid);
            chkv($sformatf("vec%0d_rdata", i), 64'(rdata), 64'(vecs[i].e_rdata));
            chk1($sformatf("vec%0d_ack", i), pwr_ack, vecs[i].e_ack);
            chk1($sformatf("vec%0d_isol", i), isol_en, vecs[i].e_isol);
            chk1($sformatf("vec%0d_penb", i), pwr_enable_b_out, vecs[i].e_penb);
            chk1($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            chk1($sformatf("vec%0d_err", i), access_err, vecs[i].e_err);
        end
        we = 1'b0; re = 1'b0; err_clr = 1'b0;

        // Abort the init sweep once entry 10 has been written
        for (int t = 1; t <= 17; t++) begin
            pwr_req = (t <= 15);
            tick();
            chk_safe();
            if (t == 15) begin
                chk1("abort_pre_isol", isol_en, 1'b0);
                chk1("abort_pre_busy", busy, 1'b1);
            end
            if (t == 16) begin
                chk1("abort_sleep_isol", isol_en, 1'b1);
                chk1("abort_sleep_penb", pwr_enable_b_out, 1'b0);
                chk1("abort_sleep_busy", busy, 1'b1);
                chk1("abort_sleep_ack", pwr_ack, 1'b0);
            end
            if (t == 17) begin
                chk1("abort_off_penb", pwr_enable_b_out, 1'b1);
                chk1("abort_off_busy", busy, 1'b0);
            end
        end
        power_up(1'b0);
        read_all_zero();

        pwr_req2 = 1'b1;
        tick();
        chk1("p2_wake_ack", pwr_ack2, 1'b0);
        chk1("p2_wake_busy", busy2, 1'b1);
        chk1("p2_wake_penb", pwr_enable_b_out2, 1'b0);
        chk1("p2_wake_isol", isol_en2, 1'b1);
        tick();
        chk1("p2_ack_at_2", pwr_ack2, 1'b1);
        chk1("p2_on_isol", isol_en2, 1'b0);
        chk1("p2_on_busy", busy2, 1'b0);
        we2 = 1'b1; waddr2 = 6'd50; wdata2 = 33'h1_2345_6789;
        tick();
        chk1("p2_oob_wr_err", access_err2, 1'b0);
        waddr2 = 6'd47; wdata2 = 33'h1_FFFF_0001;
        tick();
        we2 = 1'b0; re2 = 1'b1; raddr2 = 6'd47;
        tick();
        chk1("p2_rd47_rvalid", rvalid2, 1'b1);
        chkv("p2_rd47_rdata", 64'(rdata2), 64'h1_FFFF_0001);
        raddr2 = 6'd50;
        tick();
        chk1("p2_rd50_rvalid", rvalid2, 1'b1);
        chkv("p2_rd50_rdata", 64'(rdata2), 64'd0);
        chk1("p2_rd50_err", access_err2, 1'b0);
        raddr2 = 6'd47;
        tick();
        chkv("p2_rd47b_rdata", 64'(rdata2), 64'h1_FFFF_0001);
        re2 = 1'b0; pwr_req2 = 1'b0;
        tick();
        chk1("p2_sleep_isol", isol_en2, 1'b1);
        chk1("p2_sleep_penb", pwr_enable_b_out2, 1'b0);
        re2 = 1'b1;
        tick();
        chk1("p2_off_err", access_err2, 1'b1);
        chk1("p2_off_rvalid", rvalid2, 1'b0);
        chk1("p2_off_penb", pwr_enable_b_out2, 1'b1);
        re2 = 1'b0; pwr_req2 = 1'b1;
        tick();
        chk1("p2_rewake_penb", pwr_enable_b_out2, 1'b0);
        #2;
        rst2_n = 1'b0;
        #1;
        chk1("p2_arst_penb", pwr_enable_b_out2, 1'b1);
        chk1("p2_arst_isol", isol_en2, 1'b1);
        chk1("p2_arst_busy", busy2, 1'b0);
        chk1("p2_arst_ack", pwr_ack2, 1'b0);
        chk1("p2_arst_err", access_err2, 1'b0);
        chk1("p2_arst_rvalid", rvalid2, 1'b0);
        chkv("p2_arst_rdata", 64'(rdata2), 64'd0);
        pwr_req2 = 1'b0;
        tick();
        rst2_n = 1'b1;
        tick();
        chk1("p2_post_rst_penb", pwr_enable_b_out2, 1'b1);
        chk1("p2_post_rst_busy", busy2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
